program_loader: RTL

Boot-time loader that sits directly upstream of the CPU's program store. It receives a byte stream over a valid/ready handshake and assembles 18-bit instruction words from it. It writes those words sequentially into program memory starting at address 0, verifies an XOR checksum, and only then releases the CPU by asserting `o_cpuRun`. Until a load completes successfully the CPU is held stopped, and the instruction pointer starts from a known, fully written image.

---
 rtl/program_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte frame, assembles 18-bit words,
// writes them to program memory from address 0 and releases the CPU on a good XOR checksum.
module program_loader #(
    parameter  int ADDR_W = 16,
    localparam int WORD_W = 18
) (
    input  logic              i_clock,
    input  logic              i_resetN,
    input  logic              i_start,
    input  logic [0:7]        i_byte,
    input  logic              i_byteValid,
    output logic              o_byteReady,
    output logic [0:ADDR_W-1] o_memAddr,
    output logic [0:WORD_W-1] o_memData,
    output logic              o_memWrite,
    output logic              o_cpuRun,
    output logic              o_done,
    output logic              o_error,
    output logic [0:15]       o_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [0:15] len;          // word count N, big-endian
    logic [0:1]  b0_lo;        // only the two LSBs of B0 reach the instruction
    logic [0:7]  b1;
    logic [0:7]  chk_acc;      // running XOR of every accepted byte
    logic [0:15] count_inc;
    logic [0:15] len_full;
    logic        xfer;
    logic        start_load;
    logic        chk_ok;

    assign xfer      = i_byteValid && o_byteReady;
    assign count_inc = o_count + 16'd1;
    assign len_full  = {len[0:7], i_byte};
    assign chk_ok    = (chk_acc ^ i_byte) == 8'h00;

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next  = state;
        o_byteReady = 1'b0;
        o_memWrite  = 1'b0;
        start_load  = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    start_load = 1'b1;
                    state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                o_byteReady = 1'b1;
                if (i_byteValid) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                o_byteReady = 1'b1;
                if (i_byteValid) state_next = (len_full == 16'd0) ? S_CHK : S_B0;
            end
            S_B0: begin
                o_byteReady = 1'b1;
                if (i_byteValid) state_next = S_B1;
            end
            S_B1: begin
                o_byteReady = 1'b1;
                if (i_byteValid) state_next = S_B2;
            end
            S_B2: begin
                o_byteReady = 1'b1;
                if (i_byteValid) state_next = S_WRITE;
            end
            S_WRITE: begin
                o_memWrite = 1'b1;
                state_next = (count_inc == len) ? S_CHK : S_B0;
            end
            S_CHK: begin
                o_byteReady = 1'b1;
                if (i_byteValid) state_next = chk_ok ? S_DONE : S_ERROR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clock or negedge i_resetN) begin
        if (!i_resetN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clock or negedge i_resetN) begin
        if (!i_resetN) begin
            len       <= '0;
            b0_lo     <= '0;
            b1        <= '0;
            chk_acc   <= '0;
            o_memAddr <= '0;
            o_memData <= '0;
            o_count   <= '0;
            o_cpuRun  <= 1'b0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
        end else begin
            if (start_load) begin
                chk_acc   <= '0;
                o_memAddr <= '0;
                o_count   <= '0;
                o_cpuRun  <= 1'b0;
                o_done    <= 1'b0;
                o_error   <= 1'b0;
            end

            if (xfer) chk_acc <= chk_acc ^ i_byte;

            case (state)
                S_LEN_HI: if (xfer) len[0:7]  <= i_byte;
                S_LEN_LO: if (xfer) len[8:15] <= i_byte;
                S_B0:     if (xfer) b0_lo     <= i_byte[6:7];
                S_B1:     if (xfer) b1        <= i_byte;
                S_B2:     if (xfer) o_memData <= {b0_lo, b1, i_byte};
                S_WRITE: begin
                    // Address truncates naturally when ADDR_W < 16.
                    o_memAddr <= o_memAddr + ADDR_W'(1);
                    o_count   <= count_inc;
                end
                S_CHK: begin
                    if (xfer) begin
                        o_done   <= chk_ok;
                        o_cpuRun <= chk_ok;
                        o_error  <= !chk_ok;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
